// File: rtl/mul_accumulator.sv
// Multiply-accumulate back end: sums a stream of signed 32-bit products in a
// wide accumulator and presents a saturated 32-bit result per sum.
module mul_accumulator #(
    parameter int unsigned ACC_WIDTH = 40,
    parameter int unsigned MAX_TERMS = 256,
    parameter int unsigned CNT_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_product,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic                 out_sat,
    output logic [CNT_WIDTH-1:0] out_count
);

    typedef enum logic {
        ST_ACC,
        ST_HOLD
    } state_t;

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   acc_n;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_n;
    logic                   accept;
    logic                   end_sum;
    logic                   sat_pos;
    logic                   sat_neg;
    logic [31:0]            sat_val;

    always_comb begin
        in_ready = (state == ST_ACC) && !clear;
        accept   = in_valid && in_ready;
        acc_n    = acc + {{(ACC_WIDTH-32){in_product[31]}}, in_product};
        cnt_n    = cnt + 1'b1;
        end_sum  = in_last || (cnt_n == CNT_WIDTH'(MAX_TERMS));
        // Out of 32-bit range exactly when bits above 30 are not a pure sign copy
        sat_pos  = !acc_n[ACC_WIDTH-1] && (acc_n[ACC_WIDTH-2:31] != '0);
        sat_neg  =  acc_n[ACC_WIDTH-1] && (acc_n[ACC_WIDTH-2:31] != '1);
        if (sat_pos) begin
            sat_val = 32'h7FFF_FFFF;
        end else if (sat_neg) begin
            sat_val = 32'h8000_0000;
        end else begin
            sat_val = acc_n[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ACC;
            acc        <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_sat    <= 1'b0;
            out_count  <= '0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (clear) begin
                        acc <= '0;
                        cnt <= '0;
                    end else if (accept) begin
                        if (end_sum) begin
                            out_result <= sat_val;
                            out_sat    <= sat_pos || sat_neg;
                            out_count  <= cnt_n;
                            out_valid  <= 1'b1;
                            state      <= ST_HOLD;
                        end else begin
                            acc <= acc_n;
                            cnt <= cnt_n;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        acc       <= '0;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        state     <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_accumulator.sv
// Bench for mul_accumulator: directed scenarios plus random sums checked
// against an arithmetic reference model.
module tb_mul_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_product = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_sat;
    logic [8:0]  out_count;

    logic        b_clear = 1'b0;
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [31:0] b_in_product = '0;
    logic        b_in_last = 1'b0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [31:0] b_out_result;
    logic        b_out_sat;
    logic [2:0]  b_out_count;

    mul_accumulator dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_sat(out_sat), .out_count(out_count)
    );

    mul_accumulator #(.ACC_WIDTH(40), .MAX_TERMS(4), .CNT_WIDTH(3)) dut4 (
        .clk(clk), .rst(rst), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_product(b_in_product), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
        .out_sat(b_out_sat), .out_count(b_out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic        sat;
        int          count;
    } exp_t;

    int     checks = 0;
    int     errors = 0;
    longint m_sum = 0;
    int     m_cnt = 0;
    exp_t   exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_sum(input longint s, input int n);
        exp_t e;
        e.count = n;
        if (s > 2147483647) begin
            e.result = 32'h7FFF_FFFF;
            e.sat    = 1'b1;
        end else if (s < -longint'(2147483647) - 1) begin
            e.result = 32'h8000_0000;
            e.sat    = 1'b1;
        end else begin
            e.result = 32'(s);
            e.sat    = 1'b0;
        end
        return e;
    endfunction

    task automatic model_reset();
        m_sum = 0;
        m_cnt = 0;
    endtask

    task automatic send_term(input logic [31:0] p, input logic last);
        int unsigned n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_product = p;
        in_last = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        m_sum += longint'(signed'(p));
        m_cnt++;
        if (last || m_cnt == 256) begin
            exp_q.push_back(ref_sum(m_sum, m_cnt));
            model_reset();
        end
    endtask

    task automatic recv(input int unsigned delay, input string tag);
        int unsigned n = 0;
        exp_t e;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        for (int unsigned i = 0; i < delay; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_ready"}, in_ready, 0);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e.result = 'x;
            e.sat = 1'bx;
            e.count = -1;
        end
        chk({tag, "_result"}, out_result, e.result);
        chk({tag, "_sat"}, out_sat, e.sat);
        chk({tag, "_count"}, out_count, 9'(e.count));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_released"}, out_valid, 0);
        chk({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        int unsigned len;
        int unsigned sel;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_out_count", out_count, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Basic sum with out_ready held high
        out_ready = 1'b1;
        send_term(32'd100, 1'b0);
        send_term(-32'sd50, 1'b0);
        chk("basic_no_early_valid", out_valid, 0);
        send_term(32'd7, 1'b1);
        chk("basic_latency", out_valid, 1);
        chk("basic_const_result", out_result, 57);
        chk("basic_const_count", out_count, 3);
        chk("basic_in_ready_low", in_ready, 0);
        recv(0, "basic");

        // Positive saturation
        send_term(32'h7FFF_FFFF, 1'b0);
        send_term(32'h7FFF_FFFF, 1'b1);
        chk("possat_const_result", out_result, 32'h7FFF_FFFF);
        chk("possat_const_sat", out_sat, 1);
        recv(1, "possat");

        // Negative saturation
        send_term(32'h8000_0000, 1'b0);
        send_term(32'h8000_0000, 1'b0);
        send_term(32'h0000_0001, 1'b1);
        chk("negsat_const_result", out_result, 32'h8000_0000);
        chk("negsat_const_sat", out_sat, 1);
        recv(0, "negsat");

        // Intermediate overflow that comes back into range
        send_term(32'h7FFF_FFFF, 1'b0);
        send_term(32'd1, 1'b0);
        send_term(-32'sd2, 1'b1);
        chk("midovf_const_result", out_result, 32'h7FFF_FFFE);
        chk("midovf_const_sat", out_sat, 0);
        recv(0, "midovf");

        // Backpressure with clear pulsed while holding
        send_term(32'd1000, 1'b0);
        send_term(32'd2000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clear = (i == 2);
            chk("bp_valid", out_valid, 1);
            chk("bp_result", out_result, 3000);
            chk("bp_sat", out_sat, 0);
            chk("bp_count", out_count, 2);
            chk("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        clear = 1'b0;
        recv(0, "bp");

        // Reset mid-sum
        send_term(32'd5, 1'b0);
        send_term(32'd6, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid_no_valid", out_valid, 0);
        end
        send_term(32'd9, 1'b1);
        chk("rstmid_const_result", out_result, 9);
        chk("rstmid_const_count", out_count, 1);
        recv(0, "rstmid");

        // Clear mid-sum with a term offered in the same cycle
        send_term(32'd5, 1'b0);
        send_term(32'd6, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_product = 32'd11;
        in_last = 1'b1;
        clear = 1'b1;
        #1;
        chk("clr_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_reset();
        chk("clr_no_valid", out_valid, 0);
        send_term(32'd11, 1'b1);
        chk("clr_const_result", out_result, 11);
        chk("clr_const_count", out_count, 1);
        recv(0, "clr");

        // Forced end at MAX_TERMS=4 on the second instance
        b_out_ready = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_product = 32'd10;
        b_in_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("max_in_ready", b_in_ready, 1);
            @(negedge clk);
        end
        chk("max_valid", b_out_valid, 1);
        chk("max_result", b_out_result, 40);
        chk("max_count", b_out_count, 4);
        chk("max_in_ready_low", b_in_ready, 0);
        @(negedge clk);
        chk("max_released", b_out_valid, 0);
        chk("max_in_ready_back", b_in_ready, 1);
        b_in_last = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_last = 1'b0;
        chk("max5_valid", b_out_valid, 1);
        chk("max5_result", b_out_result, 10);
        chk("max5_count", b_out_count, 1);
        @(negedge clk);
        b_out_ready = 1'b0;

        // Random sums against the reference model
        for (int s = 0; s < 40; s++) begin
            len = $urandom_range(1, 6);
            for (int unsigned t = 0; t < len; t++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                sel = $urandom_range(0, 3);
                case (sel)
                    0: p = 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
                    1: p = 32'h8000_0000 + 32'($urandom_range(0, 3));
                    2: p = $urandom;
                    default: p = 32'($urandom_range(0, 2000)) - 32'd1000;
                endcase
                send_term(p, t == len - 1);
            end
            recv($urandom_range(0, 3), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
